// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the CoreUART receive path: state encoding and
// oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    rx_idle,
    rx_start,
    rx_data,
    rx_parity,
    rx_stop
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);

  // Index of the final data bit for the selected character width.
  function automatic logic [2:0] last_bit_idx(input logic bit8);
    return bit8 ? 3'd7 : 3'd6;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer for the asynchronous serial input; resets to the
// idle (high) line level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_async.sv
`timescale 1ns/1ps
// 16x-oversampling UART receiver with holding-register or FIFO-strobe
// delivery, sticky status flags, and the 1x transmit pacing pulse.
module uart_rx_async
  import uart_pkg::*;
#(
  parameter bit RX_FIFO = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rxrdy,
  output logic       fifo_write,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       xmit_pulse
);

  logic       w_rx_s;
  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [3:0] r_sample_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_par_err_pend;
  logic       r_done;
  logic       r_stop_bit;
  logic [3:0] r_baud_cnt;
  logic       r_xmit_pulse;

  logic [7:0] r_rx_byte;
  logic       r_rxrdy;
  logic       r_fifo_write_n;
  logic       r_parity_err;
  logic       r_framing_err;
  logic       r_overflow;

  logic       w_tick_end;
  logic       w_start_det;
  logic       w_data_sample;
  logic       w_par_sample;
  logic       w_stop_sample;
  logic       w_ovf_set;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // The start state only needs half a bit to reach mid-start; every other
  // state samples once per full bit period.
  assign w_tick_end = (r_state == rx_start) ? (r_sample_cnt == MID_TICK)
                                            : (r_sample_cnt == LAST_TICK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= rx_idle;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_det   = 1'b0;
    w_data_sample = 1'b0;
    w_par_sample  = 1'b0;
    w_stop_sample = 1'b0;
    if (baud_clock) begin
      case (r_state)
        rx_idle: begin
          if (!w_rx_s) begin
            w_state_nxt = rx_start;
            w_start_det = 1'b1;
          end
        end
        rx_start: begin
          if (w_tick_end) w_state_nxt = w_rx_s ? rx_idle : rx_data;
        end
        rx_data: begin
          if (w_tick_end) begin
            w_data_sample = 1'b1;
            if (r_bit_cnt == last_bit_idx(bit8))
              w_state_nxt = parity_en ? rx_parity : rx_stop;
          end
        end
        rx_parity: begin
          if (w_tick_end) begin
            w_par_sample = 1'b1;
            w_state_nxt  = rx_stop;
          end
        end
        rx_stop: begin
          if (w_tick_end) begin
            w_stop_sample = 1'b1;
            w_state_nxt   = rx_idle;
          end
        end
        default: w_state_nxt = rx_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample_cnt <= 4'd0;
    end else if (baud_clock) begin
      if (r_state == rx_idle || w_tick_end) r_sample_cnt <= 4'd0;
      else                                  r_sample_cnt <= r_sample_cnt + 4'd1;
    end
  end

  // Character assembly; the shift register is cleared per character so the
  // unused MSB reads 0 in 7-bit mode and drops out of the parity XOR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift        <= 8'h00;
      r_bit_cnt      <= 3'd0;
      r_par_err_pend <= 1'b0;
      r_done         <= 1'b0;
      r_stop_bit     <= 1'b1;
    end else begin
      if (w_start_det) begin
        r_shift        <= 8'h00;
        r_bit_cnt      <= 3'd0;
        r_par_err_pend <= 1'b0;
      end
      if (w_data_sample) begin
        r_shift[r_bit_cnt] <= w_rx_s;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      if (w_par_sample) r_par_err_pend <= w_rx_s ^ (^r_shift) ^ odd_n_even;
      if (w_stop_sample) r_stop_bit <= w_rx_s;
      r_done <= w_stop_sample;
    end
  end

  // Holding mode overruns when an unread character is replaced; FIFO mode
  // overruns when the FIFO cannot take the character.
  assign w_ovf_set = r_done && (RX_FIFO ? fifo_full : (r_rxrdy && !read_rx_byte));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_byte      <= 8'h00;
      r_rxrdy        <= 1'b0;
      r_fifo_write_n <= 1'b1;
      r_parity_err   <= 1'b0;
      r_framing_err  <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (r_done) r_rx_byte <= r_shift;

      if (RX_FIFO)           r_rxrdy <= 1'b0;
      else if (r_done)       r_rxrdy <= 1'b1;
      else if (read_rx_byte) r_rxrdy <= 1'b0;

      r_fifo_write_n <= !(RX_FIFO && r_done && !fifo_full);

      if (r_done && r_par_err_pend) r_parity_err <= 1'b1;
      else if (read_rx_byte)        r_parity_err <= 1'b0;

      if (r_done && !r_stop_bit) r_framing_err <= 1'b1;
      else if (read_rx_byte)     r_framing_err <= 1'b0;

      if (w_ovf_set)         r_overflow <= 1'b1;
      else if (read_rx_byte) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud_cnt   <= 4'd0;
      r_xmit_pulse <= 1'b0;
    end else begin
      if (baud_clock) r_baud_cnt <= r_baud_cnt + 4'd1;
      r_xmit_pulse <= baud_clock && (r_baud_cnt == LAST_TICK);
    end
  end

  assign rx_byte     = r_rx_byte;
  assign rxrdy       = r_rxrdy;
  assign fifo_write  = r_fifo_write_n;
  assign parity_err  = r_parity_err;
  assign framing_err = r_framing_err;
  assign overflow    = r_overflow;
  assign xmit_pulse  = r_xmit_pulse;

endmodule

// File: tb/tb_uart_rx_async.sv
`timescale 1ns/1ps
// Bench for uart_rx_async: a holding-mode and a FIFO-mode receiver share the
// serial line; FIFO writes are scored against a queue of expected characters.
module tb_uart_rx_async;

  typedef struct packed {
    logic [7:0] b;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic baud_clock = 1'b0;
  logic rx = 1'b1;
  logic bit8 = 1'b1;
  logic parity_en = 1'b0;
  logic odd_n_even = 1'b0;
  logic read_h = 1'b0;
  logic read_f = 1'b0;
  logic fifo_full_h = 1'b0;
  logic fifo_full_f = 1'b0;

  logic [7:0] h_rx_byte, f_rx_byte;
  logic h_rxrdy, f_rxrdy, h_fifo_write, f_fifo_write;
  logic h_perr, f_perr, h_ferr, f_ferr, h_ovf, f_ovf, h_xmit, f_xmit;

  int   n_tests = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  int   ticks_since = 0;
  logic bad_tie = 1'b0;
  exp_t sb_q[$];

  uart_rx_async #(.RX_FIFO(1'b0)) dut_h (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_h), .fifo_full(fifo_full_h),
    .rx_byte(h_rx_byte), .rxrdy(h_rxrdy), .fifo_write(h_fifo_write),
    .parity_err(h_perr), .framing_err(h_ferr), .overflow(h_ovf),
    .xmit_pulse(h_xmit)
  );

  uart_rx_async #(.RX_FIFO(1'b1)) dut_f (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_f), .fifo_full(fifo_full_f),
    .rx_byte(f_rx_byte), .rxrdy(f_rxrdy), .fifo_write(f_fifo_write),
    .parity_err(f_perr), .framing_err(f_ferr), .overflow(f_ovf),
    .xmit_pulse(f_xmit)
  );

  always #5 clk = ~clk;

  // 16x enable: one clk in four, changed on the falling edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      baud_clock = (div == 3);
      div = (div + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO-mode monitor: every write strobe must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n && f_fifo_write === 1'b0) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check("fifo_write_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("fifo_rx_byte", f_rx_byte, e.b);
        check("fifo_parity_err", f_perr, e.perr);
        check("fifo_framing_err", f_ferr, e.ferr);
        check("fifo_overflow", f_ovf, e.ovf);
      end
    end
    if (reset_n && (h_fifo_write !== 1'b1 || f_rxrdy !== 1'b0)) bad_tie = 1'b1;
  end

  // Transmit pacing: exactly 16 enable ticks between single-clk pulses.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      ticks_since = 0;
    end else begin
      if (baud_clock) ticks_since++;
      if (f_xmit || h_xmit) begin
        check("xmit_period", ticks_since, 16);
        check("xmit_match", h_xmit, f_xmit);
        ticks_since = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      while (!baud_clock) begin
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic read_both();
    @(negedge clk);
    read_h = 1'b1;
    read_f = 1'b1;
    @(negedge clk);
    read_h = 1'b0;
    read_f = 1'b0;
  endtask

  // Drives one frame aligned to an enable tick. Completion lands on posedge
  // 100 + 64*(data bits + parity) + 1 after the start edge; rd_done pulses
  // the holding-mode read exactly there.
  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par,
                            input bit par_bit, input bit stop_bit, input bit rd_done,
                            input exp_t e);
    if (!fifo_full_f) sb_q.push_back(e);
    wait_ticks(1);
    fork
      begin
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
          rx = data[i];
          wait_ticks(16);
        end
        if (par) begin
          rx = par_bit;
          wait_ticks(16);
        end
        rx = stop_bit;
        wait_ticks(16);
        rx = 1'b1;
      end
      begin
        if (rd_done) begin
          repeat (100 + 64 * (nbits + int'(par)) + 1) @(posedge clk);
          #1 read_h = 1'b1;
          @(posedge clk);
          #1 read_h = 1'b0;
        end
      end
    join
  endtask

  initial begin
    repeat (10) @(negedge clk);
    check("rst_rx_byte", h_rx_byte, 8'h00);
    check("rst_rxrdy", h_rxrdy, 1'b0);
    check("rst_fifo_write_h", h_fifo_write, 1'b1);
    check("rst_fifo_write_f", f_fifo_write, 1'b1);
    check("rst_status", {h_perr, h_ferr, h_ovf, f_perr, f_ferr, f_ovf}, 6'b0);
    check("rst_xmit", {h_xmit, f_xmit}, 2'b00);
    reset_n = 1'b1;
    wait_ticks(8);

    // 8N1 0x55
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    send_frame(8'h55, 8, 0, 0, 1, 0, '{8'h55, 1'b0, 1'b0, 1'b0});
    check("8n1_rxrdy", h_rxrdy, 1'b1);
    check("8n1_byte", h_rx_byte, 8'h55);
    check("8n1_status", {h_perr, h_ferr, h_ovf}, 3'b000);
    read_both();
    check("8n1_read_clears_rxrdy", h_rxrdy, 1'b0);
    wait_ticks(16);

    // 7E1 0x41: parity bit 1 is wrong, 0 is right
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h41, 7, 1, 1, 1, 0, '{8'h41, 1'b1, 1'b0, 1'b0});
    check("7e1_bad_byte", h_rx_byte, 8'h41);
    check("7e1_bad_perr", h_perr, 1'b1);
    read_both();
    check("7e1_perr_cleared", h_perr, 1'b0);
    send_frame(8'h41, 7, 1, 0, 1, 0, '{8'h41, 1'b0, 1'b0, 1'b0});
    check("7e1_good_perr", h_perr, 1'b0);
    check("7e1_good_rxrdy", h_rxrdy, 1'b1);
    read_both();

    // 8N1 0xA3 with stop bit low
    bit8 = 1'b1; parity_en = 1'b0;
    send_frame(8'hA3, 8, 0, 0, 0, 0, '{8'hA3, 1'b0, 1'b1, 1'b0});
    check("frame_byte", h_rx_byte, 8'hA3);
    check("frame_ferr", h_ferr, 1'b1);
    wait_ticks(32);
    read_both();
    check("frame_cleared", {h_ferr, h_rxrdy}, 2'b00);

    // False start: low for 4 ticks only
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(32);
    check("false_start_rxrdy", h_rxrdy, 1'b0);
    check("false_start_status", {h_perr, h_ferr, h_ovf}, 3'b000);
    check("false_start_byte", h_rx_byte, 8'hA3);

    // Holding-mode overrun, then a read in the completion cycle
    send_frame(8'h12, 8, 0, 0, 1, 0, '{8'h12, 1'b0, 1'b0, 1'b0});
    send_frame(8'h34, 8, 0, 0, 1, 0, '{8'h34, 1'b0, 1'b0, 1'b0});
    check("ovf_byte", h_rx_byte, 8'h34);
    check("ovf_set", h_ovf, 1'b1);
    check("ovf_rxrdy", h_rxrdy, 1'b1);
    read_both();
    check("ovf_cleared", h_ovf, 1'b0);
    send_frame(8'h56, 8, 0, 0, 1, 0, '{8'h56, 1'b0, 1'b0, 1'b0});
    send_frame(8'h78, 8, 0, 0, 1, 1, '{8'h78, 1'b0, 1'b0, 1'b0});
    check("rd_done_ovf", h_ovf, 1'b0);
    check("rd_done_rxrdy", h_rxrdy, 1'b1);
    check("rd_done_byte", h_rx_byte, 8'h78);
    read_both();

    // FIFO mode: write when not full, overrun when full
    send_frame(8'h7E, 8, 0, 0, 1, 0, '{8'h7E, 1'b0, 1'b0, 1'b0});
    read_both();
    fifo_full_f = 1'b1;
    send_frame(8'h7E, 8, 0, 0, 1, 0, '{8'h7E, 1'b0, 1'b0, 1'b1});
    check("fifo_full_ovf", f_ovf, 1'b1);
    check("fifo_full_holding_ovf", h_ovf, 1'b0);
    fifo_full_f = 1'b0;
    read_both();
    check("fifo_ovf_cleared", f_ovf, 1'b0);

    wait_ticks(32);
    check("sb_queue_empty", sb_q.size(), 0);
    check("fifo_write_count", n_writes, 9);
    check("tied_outputs", bad_tie, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_async.md
# uart_rx_async

Asynchronous UART receiver for the CoreUART datapath: oversamples the serial `rx` line on a 16x baud enable, recovers 7- or 8-bit characters with optional parity, and presents them either as a holding register with a ready flag or as a FIFO write strobe. It also divides the 16x baud enable down to the 1x `xmit_pulse` that paces the companion transmitter. It sits between the baud generator and the RX FIFO/holding-register logic in the UART top level.

## Interface
- `RX_FIFO`, 0: 0 = holding-register mode (`rxrdy`/`overflow` managed here); 1 = FIFO mode (`fifo_write` strobe, overflow on `fifo_full`)
- `clk  in  1  system clock; all logic on rising edge`
- `reset_n  in  1  asynchronous active-low reset; no synchronous reset path`
- `baud_clock  in  1  16x-baud enable, one `clk` wide`
- `rx  in  1  serial input, asynchronous to `clk`, idle high`
- `bit8  in  1  1 = 8 data bits, 0 = 7 data bits`
- `parity_en  in  1  parity bit present after data`
- `odd_n_even  in  1  1 = odd parity, 0 = even`
- `read_rx_byte  in  1  host read strobe (one `clk`); clears `rxrdy`, `parity_err`, `framing_err`, `overflow``
- `fifo_full  in  1  RX FIFO full (FIFO mode only)`
- `rx_byte  out  8  received character; bit 7 = 0 in 7-bit mode`
- `rxrdy  out  1  character available (holding mode; tied 0 in FIFO mode)`
- `fifo_write  out  1  active-low one-`clk` FIFO write strobe (held 1 in holding mode)`
- `parity_err  out  1  sticky parity error`
- `framing_err  out  1  sticky framing error (stop bit sampled 0)`
- `overflow  out  1  sticky overrun`
- `xmit_pulse  out  1  1x baud enable for the transmitter, one `clk` wide`

## Operation
- Reset values: `rx_byte`=0x00, `rxrdy`=0, `fifo_write`=1, `parity_err`=0, `framing_err`=0, `overflow`=0, `xmit_pulse`=0, synchronizer flops=1, state=`rx_idle`, counters=0.
- `rx` passes through a 2-flop synchronizer; all decisions use the second flop (`rx_s`).
- 4-bit sample counter advances only on `baud_clock`. States:
  - `rx_idle`: counter held 0; on `baud_clock` with `rx_s`=0 go `rx_start`.
  - `rx_start`: count 8 ticks (mid start bit); if `rx_s`=1 at that tick it is a false start -> `rx_idle`; else counter cleared -> `rx_data`.
  - `rx_data`: every 16th tick sample `rx_s` into shift register LSB-first, bit counter +1; after bit 6 (`bit8`=0) or bit 7 (`bit8`=1) go `rx_parity` if `parity_en`, else `rx_stop`.
  - `rx_parity`: sample at 16th tick; error = sampled ^ XOR(data bits) ^ `odd_n_even`; -> `rx_stop`.
  - `rx_stop`: sample at 16th tick; `framing_err` set if 0; character completes; -> `rx_idle` (stop bit remainder not waited on; a new falling edge is accepted immediately).
- Completion (holding mode): `rx_byte` loaded; if `rxrdy` already 1 and no `read_rx_byte` this cycle, `overflow`<=1 and `rx_byte` is still overwritten; `rxrdy`<=1.
- Completion (FIFO mode): if `fifo_full`=0, `fifo_write`=0 for one `clk` with `rx_byte` valid; if `fifo_full`=1, no write, `overflow`<=1.
- `parity_err`/`framing_err` set at completion; all four status bits clear on `read_rx_byte`; set wins over clear in the same cycle.
- `xmit_pulse`: independent free-running 4-bit counter on `baud_clock`; pulse when counter = 15 and `baud_clock`=1.
- `bit8`, `parity_en`, `odd_n_even` are static during a character; changes mid-character are undefined.

## Timing
- `rx` edge to `rx_s`: 2 `clk`.
- Falling edge detected to first data sample: 8 + 16 `baud_clock` ticks.
- Stop-bit sample to `rxrdy`/`fifo_write`/status update: 1 `clk` (registered).
- `fifo_write` low exactly 1 `clk` per character.
- `xmit_pulse` period: 16 `baud_clock` ticks, width 1 `clk`.
- `reset_n` deassertion mid-frame: receiver restarts in `rx_idle`; a line held low resyncs on the next tick as a start bit.

## Structure
- Shared package `uart_pkg`: state encoding (`rx_idle`, `rx_start`, `rx_data`, `rx_parity`, `rx_stop`), `OVERSAMPLE`=16, `MID_SAMPLE`=8.
- Sub-module `uart_rx_sync`: 2-flop synchronizer, reset to 1. Everything else is in one module.

## Test plan
- 8N1, `rx` frame 0x55 at 16x -> `rxrdy`=1, `rx_byte`=0x55, no errors; `read_rx_byte` clears `rxrdy`.
- 7E1, frame 0x41 with parity bit 1 (wrong) -> `rx_byte`=0x41, `parity_err`=1; correct bit 0 -> `parity_err`=0.
- 8N1 0xA3 with stop bit driven 0 -> `rx_byte`=0xA3, `framing_err`=1.
- `rx` low for 4 ticks then high -> false start, back to `rx_idle`, no `rxrdy`, no status change.
- Holding mode, two frames 0x12, 0x34 without read -> `rx_byte`=0x34, `overflow`=1; read in completion cycle -> `overflow` stays 0.
- `RX_FIFO`=1: 0x7E with `fifo_full`=0 -> one `fifo_write` low pulse; with `fifo_full`=1 -> no write, `overflow`=1; `xmit_pulse` every 16 `baud_clock` ticks throughout.
